// File: rtl/gan_pkg.sv
// Shared definitions for the generator datapath: Q8.8 format constants,
// activation encodings and the output-streamer state encoding.
package gan_pkg;

    localparam int Q88_DATA_W    = 16;
    localparam int Q88_FRAC_BITS = 8;

    localparam int ACT_NONE  = 0;
    localparam int ACT_RELU  = 1;
    localparam int ACT_LEAKY = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_STREAM    = 2'd3
    } streamer_state_e;

endpackage

// File: rtl/q88_activation.sv
// Combinational Q8.8 activation: pass-through, ReLU or LeakyReLU with a
// power-of-two negative slope (arithmetic shift, rounds toward -inf).
module q88_activation
    import gan_pkg::*;
#(
    parameter int DATA_W      = Q88_DATA_W,
    parameter int ACT_MODE    = ACT_NONE,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);

    function automatic logic signed [DATA_W-1:0] activate(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        r = v;
        if (v < 0) begin
            if (ACT_MODE == ACT_RELU) begin
                r = '0;
            end else if (ACT_MODE == ACT_LEAKY) begin
                r = v >>> LEAKY_SHIFT;
            end
        end
        return r;
    endfunction

    assign y = activate($signed(x));

endmodule

// File: rtl/layer_output_streamer.sv
// Starts a dense layer, waits for its done pulse, snapshots the flat output
// bus and streams the activated elements one per beat on a valid/ready port.
module layer_output_streamer
    import gan_pkg::*;
#(
    parameter int N_ELEM      = 256,
    parameter int DATA_W      = Q88_DATA_W,
    parameter int ACT_MODE    = ACT_NONE,
    parameter int LEAKY_SHIFT = 3,
    parameter int IDX_W       = $clog2(N_ELEM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     go,
    output logic                     busy,
    output logic                     layer_start,
    input  logic                     layer_done,
    input  logic [N_ELEM*DATA_W-1:0] layer_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [IDX_W-1:0]         m_index,
    output logic                     m_last,
    output logic                     frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    streamer_state_e          state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     start_q, start_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic                     fdone_q, fdone_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic [IDX_W-1:0]         index_q, index_d;
    logic [N_ELEM*DATA_W-1:0] snap_q, snap_d;

    logic                     beat;
    logic [IDX_W-1:0]         next_idx;
    logic [DATA_W-1:0]        act_in;
    logic [DATA_W-1:0]        act_out;

    assign beat     = valid_q & m_ready;
    assign next_idx = index_q + 1'b1;
    // Element 0 bypasses the snapshot: it is loaded in the same cycle the snapshot is captured.
    assign act_in   = (state_q == ST_WAIT_DONE) ? layer_data[DATA_W-1:0]
                                                : snap_q[DATA_W*next_idx +: DATA_W];

    q88_activation #(
        .DATA_W     (DATA_W),
        .ACT_MODE   (ACT_MODE),
        .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_act (
        .x(act_in),
        .y(act_out)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        index_d = index_q;
        snap_d  = snap_q;
        fdone_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (layer_done) begin
                    snap_d  = layer_data;
                    data_d  = act_out;
                    index_d = '0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (beat) begin
                    if (index_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        fdone_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        index_d = next_idx;
                        data_d  = act_out;
                        last_d  = (next_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d != ST_IDLE);
        start_d = (state_d == ST_START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            fdone_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            fdone_q <= fdone_d;
            data_q  <= data_d;
            index_q <= index_d;
            snap_q  <= snap_d;
        end
    end

    assign busy        = busy_q;
    assign layer_start = start_q;
    assign m_valid     = valid_q;
    assign m_last      = last_q;
    assign m_data      = data_q;
    assign m_index     = index_q;
    assign frame_done  = fdone_q;

endmodule

// File: tb/tb_layer_output_streamer.sv
// Scoreboard bench for layer_output_streamer: a 256-element pass-through
// instance plus two 8-element instances for ReLU and LeakyReLU.
module tb_layer_output_streamer;

    localparam int N  = 256;
    localparam int NS = 8;

    localparam logic [15:0] ACT_IN    [NS] = '{16'hFF00, 16'h0180, 16'h8000, 16'h7FFF,
                                               16'hFFFF, 16'h0000, 16'h0001, 16'hFFF8};
    localparam logic [15:0] RELU_EXP  [NS] = '{16'h0000, 16'h0180, 16'h0000, 16'h7FFF,
                                               16'h0000, 16'h0000, 16'h0001, 16'h0000};
    localparam logic [15:0] LEAKY_EXP [NS] = '{16'hFFE0, 16'h0180, 16'hF000, 16'h7FFF,
                                               16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             go;
    logic             busy;
    logic             layer_start;
    logic             layer_done;
    logic [N*16-1:0]  layer_data;
    logic             m_valid;
    logic             m_ready;
    logic [15:0]      m_data;
    logic [7:0]       m_index;
    logic             m_last;
    logic             frame_done;

    logic             go_s, done_s, rdy_s;
    logic [NS*16-1:0] data_s;
    logic             r_valid, r_last, r_fdone, r_busy, r_start;
    logic [15:0]      r_data;
    logic [2:0]       r_index;
    logic             k_valid, k_last, k_fdone, k_busy, k_start;
    logic [15:0]      k_data;
    logic [2:0]       k_index;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [15:0] exp_q [$];
    logic [15:0] rq [$];
    logic [15:0] lq [$];

    always #5 clk = ~clk;

    always @(negedge clk) if (layer_start === 1'b1) start_cnt <= start_cnt + 1;

    layer_output_streamer #(.N_ELEM(N), .DATA_W(16), .ACT_MODE(0), .LEAKY_SHIFT(3)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .layer_start(layer_start),
        .layer_done(layer_done), .layer_data(layer_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
        .frame_done(frame_done)
    );

    layer_output_streamer #(.N_ELEM(NS), .DATA_W(16), .ACT_MODE(1), .LEAKY_SHIFT(3)) dut_relu (
        .clk(clk), .rst_n(rst_n), .go(go_s), .busy(r_busy), .layer_start(r_start),
        .layer_done(done_s), .layer_data(data_s), .m_valid(r_valid),
        .m_ready(rdy_s), .m_data(r_data), .m_index(r_index), .m_last(r_last),
        .frame_done(r_fdone)
    );

    layer_output_streamer #(.N_ELEM(NS), .DATA_W(16), .ACT_MODE(2), .LEAKY_SHIFT(3)) dut_leaky (
        .clk(clk), .rst_n(rst_n), .go(go_s), .busy(k_busy), .layer_start(k_start),
        .layer_done(done_s), .layer_data(data_s), .m_valid(k_valid),
        .m_ready(rdy_s), .m_data(k_data), .m_index(k_index), .m_last(k_last),
        .frame_done(k_fdone)
    );

    task automatic fill(input bit rnd);
        logic [15:0] v;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            v = rnd ? 16'($urandom) : 16'(i << 8);
            layer_data[16*i +: 16] = v;
            exp_q.push_back(v);
        end
    endtask

    task automatic do_frame(input bit hold_go);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        if (!hold_go) go = 1'b0;
        checks++;
        if (layer_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: layer_start=%b busy=%b required 1 1", layer_start, busy);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || m_valid !== 1'b0 || layer_start !== 1'b0) begin
            errors++;
            $display("FAIL wait_done: busy=%b m_valid=%b layer_start=%b required 1 0 0",
                     busy, m_valid, layer_start);
        end
        layer_done = 1'b1;
    endtask

    task automatic run_stream(input int rdy_pct, input int abuse_at, input int reset_at);
        int beats = 0;
        int cyc = 0;
        bit stall = 0;
        bit abused = 0;
        logic [15:0] sd, expd;
        logic [7:0] si;
        while (beats < N && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            layer_done = 1'b0;
            if (stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== sd || m_index !== si) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h idx=%0d required 1 %h %0d",
                             m_valid, m_data, m_index, sd, si);
                end
            end
            if (reset_at >= 0 && beats == reset_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (m_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid: valid=%b busy=%b frame_done=%b required 0 0 0",
                             m_valid, busy, frame_done);
                end
                exp_q.delete();
                m_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (abuse_at >= 0 && beats == abuse_at && !abused) begin
                abused = 1;
                layer_done = 1'b1;
                layer_data = ~layer_data;
            end
            m_ready = ($urandom_range(99) < rdy_pct);
            checks++;
            if (m_valid !== 1'b1 || m_index !== 8'(beats) || m_last !== (beats == N-1)) begin
                errors++;
                $display("FAIL beat_ctrl: valid=%b idx=%0d last=%b required 1 %0d %b",
                         m_valid, m_index, m_last, beats, (beats == N-1));
            end
            if (m_ready) begin
                expd = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (m_data !== expd) begin
                    errors++;
                    $display("FAIL beat_data[%0d]: got %h required %h", beats, m_data, expd);
                end
                beats++;
            end
            stall = !m_ready;
            sd = m_data;
            si = m_index;
        end
        if (beats < N) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: beats %0d required %0d", beats, N);
            return;
        end
        @(negedge clk);
        layer_done = 1'b0;
        go = 1'b0;
        m_ready = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: frame_done=%b busy=%b valid=%b last=%b required 1 0 0 0",
                     frame_done, busy, m_valid, m_last);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_width: frame_done=%b busy=%b required 0 0", frame_done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        go = 1'b0; layer_done = 1'b0; m_ready = 1'b0; layer_data = '0;
        go_s = 1'b0; done_s = 1'b0; rdy_s = 1'b1; data_s = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 0 || layer_start !== 0 || m_valid !== 0 || m_last !== 0 ||
            frame_done !== 0 || m_data !== 16'h0 || m_index !== 8'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b start=%b valid=%b last=%b fd=%b data=%h idx=%0d required all 0",
                     busy, layer_start, m_valid, m_last, frame_done, m_data, m_index);
        end
        checks++;
        if (r_valid !== 0 || r_busy !== 0 || k_valid !== 0 || k_busy !== 0) begin
            errors++;
            $display("FAIL reset_small: r_valid=%b r_busy=%b k_valid=%b k_busy=%b required 0 0 0 0",
                     r_valid, r_busy, k_valid, k_busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int s0;
        s0 = start_cnt;
        fill(0);
        do_frame(0);
        run_stream(100, -1, -1);
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL basic_starts: got %0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_backpressure();
        fill(0);
        do_frame(0);
        run_stream(50, -1, -1);
    endtask

    task automatic test_activation();
        rq.delete();
        lq.delete();
        for (int i = 0; i < NS; i++) begin
            data_s[16*i +: 16] = ACT_IN[i];
            rq.push_back(RELU_EXP[i]);
            lq.push_back(LEAKY_EXP[i]);
        end
        @(negedge clk);
        go_s = 1'b1;
        @(negedge clk);
        go_s = 1'b0;
        repeat (3) @(negedge clk);
        done_s = 1'b1;
        @(negedge clk);
        done_s = 1'b0;
        for (int b = 0; b < NS; b++) begin
            logic [15:0] er, el;
            er = (rq.size() > 0) ? rq.pop_front() : 16'hxxxx;
            el = (lq.size() > 0) ? lq.pop_front() : 16'hxxxx;
            checks++;
            if (r_valid !== 1'b1 || r_index !== 3'(b) || r_data !== er) begin
                errors++;
                $display("FAIL relu[%0d]: valid=%b idx=%0d data=%h required 1 %0d %h",
                         b, r_valid, r_index, r_data, b, er);
            end
            checks++;
            if (k_valid !== 1'b1 || k_index !== 3'(b) || k_data !== el) begin
                errors++;
                $display("FAIL leaky[%0d]: valid=%b idx=%0d data=%h required 1 %0d %h",
                         b, k_valid, k_index, k_data, b, el);
            end
            @(negedge clk);
        end
        checks++;
        if (r_fdone !== 1'b1 || k_fdone !== 1'b1 || r_valid !== 1'b0 || k_valid !== 1'b0) begin
            errors++;
            $display("FAIL act_frame_done: r_fd=%b k_fd=%b r_v=%b k_v=%b required 1 1 0 0",
                     r_fdone, k_fdone, r_valid, k_valid);
        end
    endtask

    task automatic test_protocol_abuse();
        int s0;
        s0 = start_cnt;
        fill(1);
        do_frame(1);
        run_stream(100, 40, -1);
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL held_go_starts: got %0d required 1", start_cnt - s0);
        end
        layer_data = ~layer_data;
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (m_valid !== 1'b0 || busy !== 1'b0 || layer_start !== 1'b0) begin
                errors++;
                $display("FAIL idle_done[%0d]: valid=%b busy=%b start=%b required 0 0 0",
                         c, m_valid, busy, layer_start);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_stream();
        fill(0);
        do_frame(0);
        run_stream(100, -1, 100);
        fill(1);
        do_frame(0);
        run_stream(100, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_activation();
        test_protocol_abuse();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
